// File: rtl/drum_pkg.sv
// Shared definitions for the drum column scheduler: FSM states, default widths, zero constant.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package drum_pkg;

    localparam int DRUM_DW = 18;
    localparam int DRUM_AW = 5;

    localparam logic [DRUM_DW-1:0] DRUM_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        LOAD1,
        WAIT,
        CALC,
        DONE
    } drum_state_t;

endpackage

// File: rtl/drum_row_shifter.sv
// Three-row operand window (down/center/up plus prev/up_prev) sliding up one column.
// Latency: register moves only, values visible the cycle after load/fetch/shift.
// Backpressure: none; the scheduler FSM sequences load, fetch and shift strobes.
module drum_row_shifter
    import drum_pkg::*;
#(
    parameter int DW = DRUM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          fetch,
    input  logic          shift,
    input  logic          last_row,
    input  logic [DW-1:0] rd_curr,
    input  logic [DW-1:0] rd_prev,
    output logic [DW-1:0] center,
    output logic [DW-1:0] prev,
    output logic [DW-1:0] up,
    output logic [DW-1:0] down
);

    localparam logic [DW-1:0] ZERO = DW'(DRUM_ZERO);

    logic [DW-1:0] up_prev;

    // Window registers: prime with row 0, fetch the row above, then slide upward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            center  <= ZERO;
            prev    <= ZERO;
            up      <= ZERO;
            up_prev <= ZERO;
            down    <= ZERO;
        end else if (load) begin
            center <= rd_curr;
            prev   <= rd_prev;
            down   <= ZERO;
        end else if (fetch) begin
            // Above the top row sits the fixed drum edge.
            up      <= last_row ? ZERO : rd_curr;
            up_prev <= rd_prev;
        end else if (shift) begin
            down   <= center;
            center <= up;
            prev   <= up_prev;
        end
    end

endmodule

// File: rtl/drum_column_scheduler.sv
// Steps one drum column: reads rows, feeds the node datapath, writes u(n+1)/u(n) back in row order.
// Latency: 2*N_ROWS+3 cycles from accepted start to the done pulse.
// Backpressure: none; start is only honoured in IDLE. Optional centre tap: DRUM_CENTER_TAP_EN.
module drum_column_scheduler
    import drum_pkg::*;
#(
    parameter int N_ROWS = 30,
    parameter int DW     = DRUM_DW,
    parameter int AW     = DRUM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_curr,
    input  logic [DW-1:0] rd_prev,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_curr,
    output logic [DW-1:0] wr_prev,
    input  logic [DW-1:0] left_in,
    input  logic [DW-1:0] right_in,
    output logic [DW-1:0] node_center,
    output logic [DW-1:0] node_prev,
    output logic [DW-1:0] node_up,
    output logic [DW-1:0] node_down,
    input  logic [DW-1:0] node_next,
    output logic [DW-1:0] center_sample
);

    localparam logic [AW-1:0] LAST_ROW   = AW'(N_ROWS - 1);
    localparam logic [AW:0]   LAST_ROW_X = (AW+1)'(N_ROWS - 1);
    localparam logic [AW-1:0] TAP_ROW    = AW'(N_ROWS / 2);

    drum_state_t   state;
    drum_state_t   state_nxt;
    logic [AW-1:0] row;
    logic [AW:0]   ahead;
    logic          load;
    logic          fetch;
    logic          shift;
    logic          unused_nbr;

    // Neighbour columns are consumed by the external node datapath, not here.
    assign unused_nbr = ^{left_in, right_in};

    // Row two above the current one, kept one bit wider so the clamp sees overflow.
    assign ahead = {1'b0, row} + (AW+1)'(2);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Row counter: restarts on every new step, advances after each row write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
        end else if (state == LOAD0 || state == DONE) begin
            row <= '0;
        end else if (state == CALC) begin
            row <= row + AW'(1);
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_curr   = '0;
        wr_prev   = '0;
        load      = 1'b0;
        fetch     = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD0;
            end
            LOAD0: begin
                rd_addr   = '0;
                state_nxt = LOAD1;
            end
            LOAD1: begin
                rd_addr   = AW'(1);
                load      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                fetch     = 1'b1;
                state_nxt = CALC;
            end
            CALC: begin
                wr_en     = 1'b1;
                wr_addr   = row;
                wr_curr   = node_next;
                wr_prev   = node_center;
                rd_addr   = (ahead > LAST_ROW_X) ? LAST_ROW : ahead[AW-1:0];
                shift     = 1'b1;
                state_nxt = (row == LAST_ROW) ? DONE : WAIT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    drum_row_shifter #(
        .DW(DW)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .fetch    (fetch),
        .shift    (shift),
        .last_row (row == LAST_ROW),
        .rd_curr  (rd_curr),
        .rd_prev  (rd_prev),
        .center   (node_center),
        .prev     (node_prev),
        .up       (node_up),
        .down     (node_down)
    );

`ifdef DRUM_CENTER_TAP_EN
    logic [DW-1:0] tap;

    // Latch the mid-column result each step for the pickup output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap <= '0;
        end else if (state == CALC && row == TAP_ROW) begin
            tap <= node_next;
        end
    end

    assign center_sample = tap;
`else
    logic unused_tap;

    assign unused_tap    = ^TAP_ROW;
    assign center_sample = '0;
`endif

endmodule

// File: tb/tb_drum_column_scheduler.sv
module tb_drum_column_scheduler;

    localparam int N    = 30;
    localparam int DW   = 18;
    localparam int AW   = 5;
    localparam int STEP = 2 * N + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_curr = '0;
    logic [DW-1:0] rd_prev = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_curr;
    logic [DW-1:0] wr_prev;
    logic [DW-1:0] left_in;
    logic [DW-1:0] right_in;
    logic [DW-1:0] node_center;
    logic [DW-1:0] node_prev;
    logic [DW-1:0] node_up;
    logic [DW-1:0] node_down;
    logic [DW-1:0] node_next;
    logic [DW-1:0] center_sample;

    int   passed   = 0;
    int   total    = 0;
    int   wr_count = 0;
    logic tap_test = 1'b0;
    logic prev_pat = 1'b0;

    always #5 clk = ~clk;

    drum_column_scheduler #(
        .N_ROWS (N),
        .DW     (DW),
        .AW     (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .rd_addr       (rd_addr),
        .rd_curr       (rd_curr),
        .rd_prev       (rd_prev),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_curr       (wr_curr),
        .wr_prev       (wr_prev),
        .left_in       (left_in),
        .right_in      (right_in),
        .node_center   (node_center),
        .node_prev     (node_prev),
        .node_up       (node_up),
        .node_down     (node_down),
        .node_next     (node_next),
        .center_sample (center_sample)
    );

    assign left_in  = '0;
    assign right_in = '0;

    // Row memories: u(n) holds the row index, u(n-1) is zero or index+100; one-cycle read.
    always @(posedge clk) begin
        rd_curr <= DW'(rd_addr);
        rd_prev <= prev_pat ? DW'(rd_addr) + DW'(100) : '0;
    end

    // Stand-in node datapath: centre plus one, with a fixed value at row 15 in the tap test.
    assign node_next = (tap_test && wr_en && wr_addr == AW'(15)) ? 18'h01234 : node_center + DW'(1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // phase = -1 idle, else cycles since the accepted start edge minus one.
    int            phase     = -1;
    logic [DW-1:0] tap_model = '0;

    function automatic logic [DW-1:0] exp_next(input int r);
        if (tap_test && r == 15) return 18'h01234;
        return DW'(r + 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase     = -1;
            tap_model = '0;
        end else begin
            if (phase >= 0 && phase + 1 == 4 + 2 * (N / 2)) tap_model = exp_next(N / 2);
            if (phase < 0) begin
                if (start) phase = 0;
            end else if (phase + 1 == STEP) begin
                phase = -1;
            end else begin
                phase++;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int            c;
        int            r;
        int            ra;
        bit            calc;
        logic [DW-1:0] exp_cs;
        c    = phase + 1;
        calc = (phase >= 0) && (c >= 4) && (c % 2 == 0) && (c <= 4 + 2 * (N - 1));
        r    = (c - 4) / 2;
`ifdef DRUM_CENTER_TAP_EN
        exp_cs = tap_model;
`else
        exp_cs = '0;
`endif
        check("busy", busy, phase >= 0);
        check("done", done, (phase >= 0) && (c == STEP));
        check("wr_en", wr_en, calc);
        check("center_sample", center_sample, exp_cs);
        if (phase == 0) check("rd_addr_load0", rd_addr, 0);
        if (phase == 1) check("rd_addr_load1", rd_addr, 1);
        if (calc) begin
            ra = (r + 2 > N - 1) ? N - 1 : r + 2;
            check("wr_addr", wr_addr, r);
            check("wr_curr", wr_curr, exp_next(r));
            check("wr_prev", wr_prev, r);
            check("rd_addr_calc", rd_addr, ra);
            check("node_center", node_center, r);
            check("node_prev", node_prev, prev_pat ? r + 100 : 0);
            check("node_up", node_up, (r == N - 1) ? 0 : r + 1);
            check("node_down", node_down, (r == 0) ? 0 : r - 1);
        end
        if (wr_en) wr_count++;
    end

    // ---------------- directed stimulus ----------------
    task automatic run_step(input bit pins, output int dcyc);
        dcyc  = -1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (pins) begin
                if (cyc == 4)  check("lit_down_row0", node_down, 0);
                if (cyc == 14) check("lit_up_row5", node_up, 6);
                if (cyc == 62) check("lit_up_row29", node_up, 0);
            end
            // A start request mid-step has to be dropped.
            if (cyc == 10) start = 1'b1;
            if (cyc == 11) start = 1'b0;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check("step_timeout", 0, 1);
    endtask

    initial begin
        int d;
        int ndone;
        int dt[3];

        #1 rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_center", node_center, 0);
        check("rst_center_sample", center_sample, 0);
        #20 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single step with literal pins.
        wr_count = 0;
        run_step(1'b1, d);
        check("lit_done_cycle", d, 63);
        check("lit_writes", wr_count, 30);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;

        // start held high: back-to-back steps 64 cycles apart.
        wr_count = 0;
        ndone    = 0;
        start    = 1'b1;
        for (int i = 0; i < 400 && ndone < 3; i++) begin
            @(negedge clk);
            if (done) begin
                dt[ndone] = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("held_dones", ndone, 3);
        if (ndone == 3) begin
            check("held_period1", dt[1] - dt[0], 64);
            check("held_period2", dt[2] - dt[1], 64);
        end
        check("held_writes", wr_count, 90);
        repeat (4) @(posedge clk);
        #1;

        // Reset in cycle 20 of a step.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_done", done, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_center", node_center, 0);
        check("abort_up", node_up, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        wr_count = 0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_writes", wr_count, 0);

        // Restart after abort, with centre-tap value and nonzero u(n-1).
        tap_test = 1'b1;
        prev_pat = 1'b1;
        wr_count = 0;
        run_step(1'b1, d);
        check("restart_done_cycle", d, 63);
        check("restart_writes", wr_count, 30);
        @(posedge clk);
        #1;
`ifdef DRUM_CENTER_TAP_EN
        check("lit_tap", center_sample, 18'h01234);
`else
        check("lit_tap_off", center_sample, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/drum_column_scheduler.md
DRUM_COLUMN_SCHEDULER -- requirements
Module: drum_column_scheduler

Interface
REQ-001 SHALL have parameter N_ROWS, default 30, meaning rows per column (legal range 3..2**AW-1).
REQ-002 SHALL have parameter DW, default 18, meaning node value width (signed 1.17 fixed point).
REQ-003 SHALL have parameter AW, default 5, meaning row-memory address width.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: start  in  1  request one time step; busy  out  1  step in progress; done  out  1  one-cycle step-complete pulse.
REQ-007 SHALL have ports: rd_addr  out  AW  row read address; rd_curr  in  DW  u(n) row data; rd_prev  in  DW  u(n-1) row data (1-cycle read latency, both memories).
REQ-008 SHALL have ports: wr_en  out  1; wr_addr  out  AW; wr_curr  out  DW  u(n+1) value; wr_prev  out  DW  u(n) value.
REQ-009 SHALL have ports: left_in, right_in  in  DW  neighbour-column u(n) at current row (0 at drum edge).
REQ-010 SHALL have ports: node_center, node_prev, node_up, node_down  out  DW  operands to node datapath; node_next  in  DW  combinational u(n+1) result.
REQ-011 SHALL have port center_sample  out  DW  u(n+1) of row N_ROWS/2 from last step.

Function
REQ-012 SHALL implement states IDLE, LOAD0, LOAD1, WAIT, CALC, DONE.
REQ-013 SHALL leave IDLE only when start=1 in IDLE; start in any other state SHALL be ignored, not queued.
REQ-014 LOAD0 SHALL drive rd_addr=0; LOAD1 SHALL drive rd_addr=1 and capture rd_curr/rd_prev into center/prev registers, down register <= 0.
REQ-015 WAIT SHALL capture rd_curr/rd_prev into up/up_prev registers, except up <= 0 when current row = N_ROWS-1 (fixed edge).
REQ-016 CALC (row r) SHALL assert wr_en, wr_addr=r, wr_curr=node_next, wr_prev=center, drive rd_addr=r+2 (clamped to N_ROWS-1), then shift down<=center, center<=up, prev<=up_prev, r<=r+1.
REQ-017 CALC SHALL go to WAIT if r<N_ROWS-1, else DONE; DONE SHALL pulse done for one cycle and go to IDLE.
REQ-018 node_center/node_prev/node_up/node_down SHALL be the center/prev/up/down registers directly; left_in/right_in SHALL be consumed by the datapath in CALC.
REQ-019 Timing: start sampled at edge 0 -> first CALC at cycle 4, row r CALC at cycle 4+2r, done at cycle 2*N_ROWS+3.
REQ-020 busy SHALL be 1 in every state except IDLE; wr_en SHALL be 0 outside CALC.
REQ-021 Exactly N_ROWS writes per step, addresses 0..N_ROWS-1 ascending, each once.
REQ-022 No arithmetic on data beyond register moves; values pass bit-exact, no saturation.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, row counter 0, all data registers 0, and all outputs 0.
REQ-024 Reset mid-step SHALL abort with no further writes; memory contents are then undefined for that step.

Configuration
REQ-025 With DRUM_CENTER_TAP_EN defined, CALC for row N_ROWS/2 SHALL latch node_next into center_sample, held until next such latch or reset.
REQ-026 Without DRUM_CENTER_TAP_EN, center_sample SHALL be constant 0 and no tap register SHALL exist.

Structure
REQ-027 State enum, DW/AW defaults and a DRUM_ZERO constant SHALL live in shared package drum_pkg.
REQ-028 The node datapath is instantiated outside this block; one sub-module, drum_row_shifter (down/center/up/prev/up_prev registers plus edge zeroing), is natural.

Verification
REQ-029 N_ROWS=30, rd_curr=row index, rd_prev=0, node_next=center+1: start -> wr_addr 0..29 ascending, wr_curr=r+1, wr_prev=r, done at cycle 63.
REQ-030 Same bench: node_up at row 29 CALC=0, node_down at row 0 CALC=0, node_up at row 5 CALC=6.
REQ-031 start held high continuously -> one step per 64 cycles (63 + 1 IDLE), no overlapping writes.
REQ-032 rst=0 asserted at cycle 20 of a step -> same-edge busy=0, wr_en=0; next start restarts at row 0.
REQ-033 DRUM_CENTER_TAP_EN, node_next=18'sh01234 at row 15 -> center_sample=18'sh01234 after that CALC; macro undefined -> center_sample=0 always.
